decrement_16bit: RTL and testbench

DECREMENT_16BIT -- requirements
Module: decrement_16bit

---
 rtl/decrement_16bit.sv | 80 ++++++++
 tb/tb_decrement_16bit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/decrement_16bit.sv
// Registered 16-bit two's-complement decrement (A-1) built as a ripple-borrow chain, with a signed-overflow flag.
// Define DEC16_STICKY_OVF_EN to add the ovf_sticky output that accumulates overflow until reset.
module decrement_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] A,
  output logic [15:0] decA,
  output logic        overflow,
`ifdef DEC16_STICKY_OVF_EN
  output logic        ovf_sticky,
`endif
  output logic        out_valid
);

  logic [15:0] borrow;
  logic [15:0] diff;
  logic        ovf_next;

  logic [15:0] dec_a_d, dec_a_q;
  logic        ovf_d, ovf_q;
  logic        out_valid_d, out_valid_q;

  // Cell 0 borrows the constant 1; every later cell borrows only from the cell below.
  always_comb begin
    borrow    = '0;
    diff      = '0;
    borrow[0] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      diff[i] = A[i] ^ borrow[i];
      if (i < 15) borrow[i+1] = ~A[i] & borrow[i];
    end
    // A negative operand that yields a non-negative result can only be 16'h8000.
    ovf_next = A[15] & ~diff[15];
  end

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    dec_a_d     = dec_a_q;
    ovf_d       = ovf_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      dec_a_d = diff;
      ovf_d   = ovf_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_a_q     <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      dec_a_q     <= dec_a_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef DEC16_STICKY_OVF_EN
  logic sticky_d, sticky_q;

  always_comb begin
    sticky_d = sticky_q | (in_valid & ovf_next);
  end

  always_ff @(posedge clk) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
`endif

  assign decA      = dec_a_q;
  assign overflow  = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_decrement_16bit.sv
// Self-checking bench for decrement_16bit: directed vectors plus randomized traffic against an arithmetic reference model.
module tb_decrement_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a_in;
  logic [15:0] dec_a;
  logic        overflow;
  logic        out_valid;
`ifdef DEC16_STICKY_OVF_EN
  logic        ovf_sticky;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, updated from the operand rules (A-1 mod 2^16, overflow only at the most negative value).
  logic [15:0] exp_dec;
  logic        exp_ovf;
  logic        exp_vld;
  logic        exp_sticky;

  decrement_16bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (a_in),
    .decA      (dec_a),
    .overflow  (overflow),
`ifdef DEC16_STICKY_OVF_EN
    .ovf_sticky(ovf_sticky),
`endif
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance past the edge, update the model and compare every output.
  task automatic step(input logic r, input logic v, input logic [15:0] a, input string tag);
    rst      = r;
    in_valid = v;
    a_in     = a;
    @(posedge clk);
    #1;
    if (r) begin
      exp_dec    = 16'h0000;
      exp_ovf    = 1'b0;
      exp_vld    = 1'b0;
      exp_sticky = 1'b0;
    end else if (v) begin
      exp_dec    = a - 16'd1;
      exp_ovf    = (a == 16'h8000);
      exp_vld    = 1'b1;
      exp_sticky = exp_sticky | exp_ovf;
    end else begin
      exp_vld = 1'b0;
    end
    check({tag, ".decA"},      dec_a,            exp_dec);
    check({tag, ".overflow"},  {15'd0, overflow}, {15'd0, exp_ovf});
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, exp_vld});
`ifdef DEC16_STICKY_OVF_EN
    check({tag, ".ovf_sticky"}, {15'd0, ovf_sticky}, {15'd0, exp_sticky});
`endif
  endtask

  initial begin
    logic [15:0] held;
    logic        r, v;
    logic [15:0] a;

    rst = 1'b1; in_valid = 1'b0; a_in = 16'h0000;
    exp_dec = '0; exp_ovf = 1'b0; exp_vld = 1'b0; exp_sticky = 1'b0;

    // Two reset cycles, then one idle cycle after release.
    step(1'b1, 1'b0, 16'h0000, "reset0");
    step(1'b1, 1'b0, 16'h0000, "reset1");
    step(1'b0, 1'b0, 16'h0000, "post_reset");
    check("reset_decA_zero", dec_a, 16'h0000);

    step(1'b0, 1'b1, 16'h0000, "zero");
    check("zero_wraps_to_ffff", dec_a, 16'hFFFF);
    check("zero_no_overflow", {15'd0, overflow}, 16'd0);
    step(1'b0, 1'b1, 16'd10, "ten");
    check("ten_gives_nine", dec_a, 16'd9);
    step(1'b0, 1'b1, 16'hFE5C, "neg420");
    check("neg420_gives_neg421", dec_a, 16'hFE5B);
    step(1'b0, 1'b1, 16'h8000, "most_neg");
    check("most_neg_wraps", dec_a, 16'h7FFF);
    check("most_neg_overflow", {15'd0, overflow}, 16'd1);
    step(1'b0, 1'b1, 16'd5, "after_ovf");
    check("after_ovf_clears_flag", {15'd0, overflow}, 16'd0);

    // Back-to-back operands, one per clock.
    step(1'b0, 1'b1, 16'h0001, "b2b0");
    check("b2b0_value", dec_a, 16'h0000);
    step(1'b0, 1'b1, 16'h7FFF, "b2b1");
    check("b2b1_value", dec_a, 16'h7FFE);
    step(1'b0, 1'b1, 16'hFFFF, "b2b2");
    check("b2b2_value", dec_a, 16'hFFFE);

    // Operand presented together with reset is discarded.
    step(1'b1, 1'b1, 16'h1234, "rst_with_op");
    check("rst_with_op_no_valid", {15'd0, out_valid}, 16'd0);
    step(1'b0, 1'b1, 16'h0100, "first_after_rst");
    check("first_after_rst_valid", {15'd0, out_valid}, 16'd1);

    // Idle cycles hold the previous result.
    held = dec_a;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'hABCD, "idle");
    check("idle_holds_decA", dec_a, held);

    // Randomized traffic with occasional reset and forced boundary operands.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       a = 16'h8000;
        1:       a = 16'h0000;
        2:       a = 16'h7FFF;
        default: a = 16'($urandom);
      endcase
      step(r, v, a, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
